// File: rtl/sw_debounce_led.sv
`default_nettype none
// ============================================================================
//  Module   : sw_debounce_led
//  Purpose  : Multi-channel switch front end. Synchronises and debounces raw
//             switch inputs, emits one-cycle rise/fall pulses and drives one
//             LED per channel in follow, toggle, blink or stretch mode.
//  Revision : 1.0 - initial release
// ============================================================================
module sw_debounce_led #(
    parameter int N_CH            = 2,
    parameter int SYNC_STAGES     = 2,
    parameter int DEBOUNCE_CYCLES = 1000000,
    parameter int BLINK_HALF      = 25000000
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [N_CH-1:0]   sw_i,
    input  logic [2*N_CH-1:0] mode_i,
    output logic [N_CH-1:0]   sw_o,
    output logic [N_CH-1:0]   rise_o,
    output logic [N_CH-1:0]   fall_o,
    output logic [N_CH-1:0]   led_o
);

    localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
    localparam int BLK_W = $clog2(BLINK_HALF);
    localparam int STR_W = $clog2(BLINK_HALF + 1);

    localparam logic [CNT_W-1:0] C_DEB_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [BLK_W-1:0] C_BLK_LAST = BLK_W'(BLINK_HALF - 1);
    localparam logic [STR_W-1:0] C_STR_LOAD = STR_W'(BLINK_HALF);

    localparam logic [1:0] C_MODE_FOLLOW  = 2'b00;
    localparam logic [1:0] C_MODE_TOGGLE  = 2'b01;
    localparam logic [1:0] C_MODE_BLINK   = 2'b10;
    localparam logic [1:0] C_MODE_STRETCH = 2'b11;

    // ------------------------------------------------------------------
    // Shared blink timebase: free-running, not aligned to any press.
    // ------------------------------------------------------------------
    logic [BLK_W-1:0] blk_cnt_q, blk_cnt_d;
    logic             phase_q, phase_d;

    // Wrap the counter at BLINK_HALF-1 and flip the phase on each wrap.
    always_comb begin
        blk_cnt_d = blk_cnt_q + 1'b1;
        phase_d   = phase_q;
        if (blk_cnt_q == C_BLK_LAST) begin
            blk_cnt_d = '0;
            phase_d   = ~phase_q;
        end
    end

    // Blink timebase registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            blk_cnt_q <= '0;
            phase_q   <= 1'b0;
        end else begin
            blk_cnt_q <= blk_cnt_d;
            phase_q   <= phase_d;
        end
    end

    // ------------------------------------------------------------------
    // Per-channel datapath; channels share nothing but the blink phase.
    // ------------------------------------------------------------------
    for (genvar k = 0; k < N_CH; k++) begin : g_ch
        logic [SYNC_STAGES-1:0] sync_q;
        logic                   s_w;
        logic [CNT_W-1:0]       cnt_q, cnt_d;
        logic                   lvl_q, lvl_d;
        logic                   rise_q, rise_d;
        logic                   fall_q, fall_d;
        logic                   tgl_q, tgl_d;
        logic [STR_W-1:0]       str_q, str_d;
        logic                   led_q, led_d;
        logic [1:0]             mode_w;

        assign s_w    = sync_q[SYNC_STAGES-1];
        assign mode_w = mode_i[2*k +: 2];

        // Synchroniser chain; bit 0 samples the raw pin.
        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                sync_q <= '0;
            end else begin
                sync_q <= {sync_q[SYNC_STAGES-2:0], sw_i[k]};
            end
        end

        // Debounce decision, LED state updates and LED mode selection.
        always_comb begin
            cnt_d  = cnt_q;
            lvl_d  = lvl_q;
            rise_d = 1'b0;
            fall_d = 1'b0;
            if (s_w == lvl_q) begin
                cnt_d = '0;
            end else if (cnt_q == C_DEB_LAST) begin
                lvl_d  = s_w;
                cnt_d  = '0;
                rise_d = s_w;
                fall_d = ~s_w;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end

            // Toggle and stretch react in the same edge as the rise pulse
            // so the LED (registered from these) follows one cycle later.
            tgl_d = tgl_q ^ rise_d;
            if (rise_d) begin
                str_d = C_STR_LOAD;
            end else if (str_q != '0) begin
                str_d = str_q - 1'b1;
            end else begin
                str_d = '0;
            end

            led_d = 1'b0;
            case (mode_w)
                C_MODE_FOLLOW:  led_d = lvl_q;
                C_MODE_TOGGLE:  led_d = tgl_q;
                C_MODE_BLINK:   led_d = lvl_q & phase_q;
                C_MODE_STRETCH: led_d = (str_q != '0);
                default:        led_d = 1'b0;
            endcase
        end

        // Channel state registers.
        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                cnt_q  <= '0;
                lvl_q  <= 1'b0;
                rise_q <= 1'b0;
                fall_q <= 1'b0;
                tgl_q  <= 1'b0;
                str_q  <= '0;
                led_q  <= 1'b0;
            end else begin
                cnt_q  <= cnt_d;
                lvl_q  <= lvl_d;
                rise_q <= rise_d;
                fall_q <= fall_d;
                tgl_q  <= tgl_d;
                str_q  <= str_d;
                led_q  <= led_d;
            end
        end

        assign sw_o[k]   = lvl_q;
        assign rise_o[k] = rise_q;
        assign fall_o[k] = fall_q;
        assign led_o[k]  = led_q;
    end

endmodule
`default_nettype wire

// File: tb/tb_sw_debounce_led.sv
`default_nettype none
// ============================================================================
//  Module   : tb_sw_debounce_led
//  Purpose  : Directed self-checking bench for sw_debounce_led
//             (N_CH=2, SYNC_STAGES=2, DEBOUNCE_CYCLES=4, BLINK_HALF=8).
//  Revision : 1.0 - initial release
// ============================================================================
module tb_sw_debounce_led;

    logic       clk = 1'b0;
    logic       rst;
    logic [1:0] sw_i;
    logic [3:0] mode_i;
    logic [1:0] sw_o, rise_o, fall_o, led_o;

    int total = 0;
    int bad   = 0;

    sw_debounce_led #(
        .N_CH(2), .SYNC_STAGES(2), .DEBOUNCE_CYCLES(4), .BLINK_HALF(8)
    ) dut (
        .clk(clk), .rst(rst), .sw_i(sw_i), .mode_i(mode_i),
        .sw_o(sw_o), .rise_o(rise_o), .fall_o(fall_o), .led_o(led_o)
    );

    always #5 clk = ~clk;

    // Advance past the next rising edge and settle.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reset with switches low; the edge after return is the first live one.
    task automatic apply_reset();
        sw_i = 2'b00;
        rst  = 1'b1;
        tick();
        tick();
        rst  = 1'b0;
    endtask

    task automatic test_reset();
        mode_i = 4'b0000;
        sw_i   = 2'b11;
        repeat (8) tick();
        total++;
        if (sw_o !== 2'b11) begin bad++; $display("FAIL reset_pre_sw got=%b exp=11", sw_o); end
        total++;
        if (led_o !== 2'b11) begin bad++; $display("FAIL reset_pre_led got=%b exp=11", led_o); end
        #2 rst = 1'b1;
        #1;
        total++;
        if ({sw_o, rise_o, fall_o, led_o} !== 8'h00) begin
            bad++; $display("FAIL reset_async got=%b exp=00000000", {sw_o, rise_o, fall_o, led_o});
        end
        tick();
        rst = 1'b0;
        repeat (5) tick();
        total++;
        if (sw_o !== 2'b00) begin bad++; $display("FAIL reset_early_sw got=%b exp=00", sw_o); end
        tick();
        total++;
        if (sw_o !== 2'b11) begin bad++; $display("FAIL reset_return_sw got=%b exp=11", sw_o); end
        total++;
        if (rise_o !== 2'b11) begin bad++; $display("FAIL reset_return_rise got=%b exp=11", rise_o); end
    endtask

    task automatic test_clean_press();
        logic [1:0] e_sw, e_rise, e_fall, e_led;
        apply_reset();
        mode_i = 4'b0000;
        sw_i   = 2'b01;
        for (int t = 1; t <= 7; t++) begin
            tick();
            e_sw   = (t >= 6) ? 2'b01 : 2'b00;
            e_rise = (t == 6) ? 2'b01 : 2'b00;
            e_led  = (t == 7) ? 2'b01 : 2'b00;
            total++;
            if (sw_o !== e_sw) begin bad++; $display("FAIL press_sw t=%0d got=%b exp=%b", t, sw_o, e_sw); end
            total++;
            if (rise_o !== e_rise) begin bad++; $display("FAIL press_rise t=%0d got=%b exp=%b", t, rise_o, e_rise); end
            total++;
            if (led_o !== e_led) begin bad++; $display("FAIL press_led t=%0d got=%b exp=%b", t, led_o, e_led); end
        end
        sw_i = 2'b00;
        for (int t = 1; t <= 7; t++) begin
            tick();
            e_sw   = (t >= 6) ? 2'b00 : 2'b01;
            e_fall = (t == 6) ? 2'b01 : 2'b00;
            e_led  = (t >= 7) ? 2'b00 : 2'b01;
            total++;
            if (sw_o !== e_sw) begin bad++; $display("FAIL release_sw t=%0d got=%b exp=%b", t, sw_o, e_sw); end
            total++;
            if (fall_o !== e_fall) begin bad++; $display("FAIL release_fall t=%0d got=%b exp=%b", t, fall_o, e_fall); end
            total++;
            if (led_o !== e_led) begin bad++; $display("FAIL release_led t=%0d got=%b exp=%b", t, led_o, e_led); end
        end
    endtask

    task automatic test_bounce();
        logic [1:0] e_sw, e_rise, e_fall, e_led;
        apply_reset();
        mode_i = 4'b0000;
        sw_i   = 2'b01;
        for (int t = 1; t <= 10; t++) begin
            tick();
            if (t == 3) sw_i = 2'b00;
            total++;
            if ({sw_o, rise_o, fall_o, led_o} !== 8'h00) begin
                bad++; $display("FAIL bounce_short t=%0d got=%b exp=00000000", t, {sw_o, rise_o, fall_o, led_o});
            end
        end
        sw_i = 2'b01;
        for (int t = 1; t <= 12; t++) begin
            tick();
            if (t == 4) sw_i = 2'b00;
            e_sw   = (t >= 6 && t < 10) ? 2'b01 : 2'b00;
            e_rise = (t == 6)  ? 2'b01 : 2'b00;
            e_fall = (t == 10) ? 2'b01 : 2'b00;
            e_led  = (t >= 7 && t < 11) ? 2'b01 : 2'b00;
            total++;
            if ({sw_o, rise_o, fall_o, led_o} !== {e_sw, e_rise, e_fall, e_led}) begin
                bad++;
                $display("FAIL bounce_min t=%0d got=%b exp=%b", t,
                         {sw_o, rise_o, fall_o, led_o}, {e_sw, e_rise, e_fall, e_led});
            end
        end
    endtask

    task automatic test_toggle();
        apply_reset();
        mode_i = 4'b0101;
        sw_i   = 2'b01;
        repeat (6) tick();
        total++;
        if (rise_o !== 2'b01 || led_o !== 2'b00) begin
            bad++; $display("FAIL toggle_rise1 got=%b%b exp=0100", rise_o, led_o);
        end
        tick();
        total++;
        if (led_o !== 2'b01) begin bad++; $display("FAIL toggle_on got=%b exp=01", led_o); end
        sw_i = 2'b00;
        for (int t = 1; t <= 10; t++) begin
            tick();
            total++;
            if (led_o !== 2'b01) begin bad++; $display("FAIL toggle_hold t=%0d got=%b exp=01", t, led_o); end
        end
        sw_i = 2'b01;
        repeat (6) tick();
        total++;
        if (rise_o !== 2'b01 || led_o !== 2'b01) begin
            bad++; $display("FAIL toggle_rise2 got=%b%b exp=0101", rise_o, led_o);
        end
        tick();
        total++;
        if (led_o !== 2'b00) begin bad++; $display("FAIL toggle_off got=%b exp=00", led_o); end
    endtask

    task automatic test_blink();
        logic       e;
        logic [1:0] e_fall;
        apply_reset();
        mode_i = 4'b1000;
        sw_i   = 2'b10;
        for (int n = 1; n <= 112; n++) begin
            tick();
            if (n == 100) sw_i = 2'b00;
            e      = (n >= 7) && (n <= 106) && ((((n - 1) / 8) % 2) == 1);
            e_fall = (n == 106) ? 2'b10 : 2'b00;
            total++;
            if (led_o !== {e, 1'b0}) begin bad++; $display("FAIL blink_led n=%0d got=%b exp=%b", n, led_o, {e, 1'b0}); end
            total++;
            if (fall_o !== e_fall) begin bad++; $display("FAIL blink_fall n=%0d got=%b exp=%b", n, fall_o, e_fall); end
        end
    endtask

    task automatic test_stretch();
        logic [1:0] e_rise, e_led;
        apply_reset();
        mode_i = 4'b0011;
        sw_i   = 2'b01;
        for (int t = 1; t <= 16; t++) begin
            tick();
            if (t == 6) sw_i = 2'b00;
            e_rise = (t == 6) ? 2'b01 : 2'b00;
            e_led  = (t >= 7 && t <= 14) ? 2'b01 : 2'b00;
            total++;
            if ({rise_o, led_o} !== {e_rise, e_led}) begin
                bad++; $display("FAIL stretch t=%0d got=%b exp=%b", t, {rise_o, led_o}, {e_rise, e_led});
            end
        end
    endtask

    // Retrigger the stretch with the fastest possible second rise.
    task automatic test_back_to_back();
        logic [1:0] e_rise, e_led;
        apply_reset();
        mode_i = 4'b0011;
        sw_i   = 2'b01;
        for (int t = 1; t <= 26; t++) begin
            tick();
            if (t == 4)  sw_i = 2'b00;
            if (t == 8)  sw_i = 2'b01;
            if (t == 16) sw_i = 2'b00;
            e_rise = (t == 6 || t == 14) ? 2'b01 : 2'b00;
            e_led  = (t >= 7 && t <= 22) ? 2'b01 : 2'b00;
            total++;
            if ({rise_o, led_o} !== {e_rise, e_led}) begin
                bad++; $display("FAIL retrigger t=%0d got=%b exp=%b", t, {rise_o, led_o}, {e_rise, e_led});
            end
        end
    endtask

    task automatic test_reset_mid_stretch();
        apply_reset();
        mode_i = 4'b0011;
        sw_i   = 2'b01;
        repeat (9) tick();
        total++;
        if (led_o !== 2'b01) begin bad++; $display("FAIL midrst_pre got=%b exp=01", led_o); end
        sw_i = 2'b00;
        #2 rst = 1'b1;
        #1;
        total++;
        if ({sw_o, rise_o, fall_o, led_o} !== 8'h00) begin
            bad++; $display("FAIL midrst_async got=%b exp=00000000", {sw_o, rise_o, fall_o, led_o});
        end
        tick();
        rst = 1'b0;
        for (int t = 1; t <= 10; t++) begin
            tick();
            total++;
            if ({sw_o, rise_o, fall_o, led_o} !== 8'h00) begin
                bad++; $display("FAIL midrst_after t=%0d got=%b exp=00000000", t, {sw_o, rise_o, fall_o, led_o});
            end
        end
    endtask

    initial begin
        rst    = 1'b1;
        sw_i   = 2'b00;
        mode_i = 4'b0000;
        tick();
        tick();
        rst = 1'b0;
        test_reset();
        test_clean_press();
        test_bounce();
        test_toggle();
        test_blink();
        test_stretch();
        test_back_to_back();
        test_reset_mid_stretch();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
